// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch queue and its group unpacker.
package fetch_pkg;
    localparam int INST_W      = 32;
    localparam int FETCH_WIDTH = 4;
    localparam int DEC_WIDTH   = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] target;
    } fq_entry_t;
endpackage

// File: rtl/fetch_group_unpack.sv
// Compacts the live slots of one fetch group into lanes 0..n_in-1; purely combinational.
module fetch_group_unpack
    import fetch_pkg::*;
(
    input  logic [31:0]                   in_pc,
    input  logic [FETCH_WIDTH*INST_W-1:0] in_inst,
    input  logic                          in_taken,
    input  logic [1:0]                    in_taken_slot,
    input  logic [31:0]                   in_target,
    output logic [2:0]                    n_in,
    output fq_entry_t [FETCH_WIDTH-1:0]   lanes
);
    logic [1:0] start;
    logic [1:0] last;
    logic       keep_taken;
    logic       unused_pc_lo;

    assign unused_pc_lo = ^in_pc[1:0];

    // A taken slot before the entry point cannot be the branch we fetched through.
    assign start      = in_pc[3:2];
    assign keep_taken = in_taken && (in_taken_slot >= start);
    assign last       = keep_taken ? in_taken_slot : 2'd3;
    assign n_in       = {1'b0, last} - {1'b0, start} + 3'd1;

    always_comb begin
        logic [1:0] slot;
        lanes = '0;
        slot  = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            slot            = start + 2'(k);
            lanes[k].pc     = {in_pc[31:4], slot, 2'b00};
            lanes[k].inst   = in_inst[INST_W*slot +: INST_W];
            lanes[k].taken  = keep_taken && (slot == last);
            lanes[k].target = (keep_taken && (slot == last)) ? in_target : 32'd0;
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch (up to 4/cycle) and decode (2/cycle); 1-cycle enqueue-to-output.
// Accepts a group only when 4 entries are free; flush and reset empty it.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_pc,
    input  logic [FETCH_WIDTH*INST_W-1:0] in_inst,
    input  logic                          in_taken,
    input  logic [1:0]                    in_taken_slot,
    input  logic [31:0]                   in_target,
    output logic [DEC_WIDTH-1:0]          out_valid,
    output logic [31:0]                   out_pc0,
    output logic [31:0]                   out_pc1,
    output logic [31:0]                   out_inst0,
    output logic [31:0]                   out_inst1,
    output logic                          out_taken0,
    output logic                          out_taken1,
    output logic [31:0]                   out_target0,
    output logic [31:0]                   out_target1,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH):0]        count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t                        mem_q [DEPTH];
    fq_entry_t [FETCH_WIDTH-1:0]      lanes;
    logic [2:0]                       n_in;
    logic [1:0]                       n_out;
    logic [PW-1:0]                    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]                    count_q, count_d, free;
    logic                             enq, deq;
    fq_entry_t                        e0, e1;

    fetch_group_unpack u_unpack (
        .in_pc         (in_pc),
        .in_inst       (in_inst),
        .in_taken      (in_taken),
        .in_taken_slot (in_taken_slot),
        .in_target     (in_target),
        .n_in          (n_in),
        .lanes         (lanes)
    );

    // Readiness looks only at registered occupancy so it never depends on out_ready.
    assign free     = CW'(DEPTH) - count_q;
    assign in_ready = !reset && (free >= CW'(FETCH_WIDTH));
    assign enq      = in_valid && in_ready && !flush;

    assign out_valid = (count_q == '0)     ? 2'b00 :
                       (count_q == CW'(1)) ? 2'b01 : 2'b11;
    assign n_out     = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};
    assign deq       = out_ready && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + PW'(n_in);
            end
            if (deq) begin
                head_d = head_q + PW'(n_out);
            end
            count_d = count_q + (enq ? CW'(n_in) : CW'(0)) - (deq ? CW'(n_out) : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left uninitialised; count gates every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (3'(k) < n_in) begin
                    mem_q[tail_q + PW'(k)] <= lanes[k];
                end
            end
        end
    end

    assign e0 = mem_q[head_q];
    assign e1 = mem_q[head_q + PW'(1)];

    assign out_pc0     = e0.pc;
    assign out_pc1     = e1.pc;
    assign out_inst0   = e0.inst;
    assign out_inst1   = e1.inst;
    assign out_taken0  = e0.taken;
    assign out_taken1  = e1.taken;
    assign out_target0 = e0.target;
    assign out_target1 = e1.target;
    assign count       = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed checks of fetch_queue: slot unpacking, occupancy, full boundary, wrap, flush, reset.
module tb_fetch_queue;
    logic         clk = 1'b0;
    logic         reset, flush, in_valid, in_ready;
    logic [31:0]  in_pc, in_target;
    logic [127:0] in_inst;
    logic         in_taken;
    logic [1:0]   in_taken_slot;
    logic [1:0]   out_valid;
    logic [31:0]  out_pc0, out_pc1, out_inst0, out_inst1, out_target0, out_target1;
    logic         out_taken0, out_taken1, out_ready;
    logic [4:0]   count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .in_taken(in_taken), .in_taken_slot(in_taken_slot), .in_target(in_target),
        .out_valid(out_valid), .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_taken0(out_taken0), .out_taken1(out_taken1),
        .out_target0(out_target0), .out_target1(out_target1),
        .out_ready(out_ready), .count(count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Instruction word of each slot encodes its own PC so lane data is predictable.
    task automatic set_group(input logic [31:0] pc, input logic tk, input logic [1:0] slot,
                             input logic [31:0] tgt);
        in_pc         = pc;
        in_taken      = tk;
        in_taken_slot = slot;
        in_target     = tgt;
        for (int s = 0; s < 4; s++)
            in_inst[32*s +: 32] = 32'hE000_0000 + {pc[31:4], 2'(s), 2'b00};
        in_valid = 1'b1;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [1:0] slot,
                        input logic [31:0] tgt);
        set_group(pc, tk, slot, tgt);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic lane0(input string tag, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt);
        check({tag, ".pc0"}, out_pc0, pc);
        check({tag, ".inst0"}, out_inst0, 32'hE000_0000 + pc);
        check({tag, ".tk0"}, {31'd0, out_taken0}, {31'd0, tk});
        check({tag, ".tgt0"}, out_target0, tgt);
    endtask

    task automatic lane1(input string tag, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt);
        check({tag, ".pc1"}, out_pc1, pc);
        check({tag, ".inst1"}, out_inst1, 32'hE000_0000 + pc);
        check({tag, ".tk1"}, {31'd0, out_taken1}, {31'd0, tk});
        check({tag, ".tgt1"}, out_target1, tgt);
    endtask

    task automatic occ(input string tag, input int c, input logic [1:0] v, input logic rdy);
        check({tag, ".count"}, {27'd0, count}, c);
        check({tag, ".valid"}, {30'd0, out_valid}, {30'd0, v});
        check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0; in_taken = 1'b0; in_taken_slot = '0; in_target = '0;
        tick(); tick();
        check("rst.in_ready_held", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        occ("rst", 0, 2'b00, 1'b1);

        // Aligned group, decode always ready
        out_ready = 1'b1;
        push(32'h100, 1'b0, 2'd0, 32'h0);
        occ("g100a", 4, 2'b11, 1'b1);
        lane0("g100a", 32'h100, 1'b0, 32'h0);
        lane1("g100a", 32'h104, 1'b0, 32'h0);
        tick();
        occ("g100b", 2, 2'b11, 1'b1);
        lane0("g100b", 32'h108, 1'b0, 32'h0);
        lane1("g100b", 32'h10C, 1'b0, 32'h0);
        tick();
        occ("g100c", 0, 2'b00, 1'b1);

        // Mid-group entry point
        out_ready = 1'b0;
        push(32'h208, 1'b0, 2'd0, 32'h0);
        occ("g208", 2, 2'b11, 1'b1);
        lane0("g208", 32'h208, 1'b0, 32'h0);
        lane1("g208", 32'h20C, 1'b0, 32'h0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        occ("g208d", 0, 2'b00, 1'b1);

        // Taken slot below start is ignored
        push(32'h204, 1'b1, 2'd0, 32'h999);
        occ("g204", 3, 2'b11, 1'b1);
        lane0("g204", 32'h204, 1'b0, 32'h0);
        lane1("g204", 32'h208, 1'b0, 32'h0);
        out_ready = 1'b1; tick();
        occ("g204b", 1, 2'b01, 1'b1);
        lane0("g204b", 32'h20C, 1'b0, 32'h0);
        tick(); out_ready = 1'b0;
        occ("g204c", 0, 2'b00, 1'b1);

        // Kept taken branch truncates the group
        push(32'h300, 1'b1, 2'd1, 32'h400);
        occ("g300", 2, 2'b11, 1'b1);
        lane0("g300", 32'h300, 1'b0, 32'h0);
        lane1("g300", 32'h304, 1'b1, 32'h400);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        occ("g300d", 0, 2'b00, 1'b1);

        // Full boundary
        push(32'h600, 1'b0, 2'd0, 32'h0);
        push(32'h610, 1'b0, 2'd0, 32'h0);
        push(32'h620, 1'b0, 2'd0, 32'h0);
        occ("full12", 12, 2'b11, 1'b1);
        push(32'h630, 1'b0, 2'd0, 32'h0);
        occ("full16", 16, 2'b11, 1'b0);
        lane0("full16", 32'h600, 1'b0, 32'h0);
        push(32'h640, 1'b0, 2'd0, 32'h0);
        occ("full_blocked", 16, 2'b11, 1'b0);
        out_ready = 1'b1; tick();
        occ("full14", 14, 2'b11, 1'b0);
        lane0("full14", 32'h608, 1'b0, 32'h0);
        tick();
        occ("full12b", 12, 2'b11, 1'b1);
        lane0("full12b", 32'h610, 1'b0, 32'h0);
        repeat (6) tick();
        occ("full_drained", 0, 2'b00, 1'b1);

        // Advance head/tail to 14, then wrap
        out_ready = 1'b0;
        push(32'h704, 1'b0, 2'd0, 32'h0);
        out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
        occ("pre_wrap", 0, 2'b00, 1'b1);
        push(32'h500, 1'b0, 2'd0, 32'h0);
        occ("wrap_a", 4, 2'b11, 1'b1);
        lane0("wrap_a", 32'h500, 1'b0, 32'h0);
        lane1("wrap_a", 32'h504, 1'b0, 32'h0);
        out_ready = 1'b1; tick();
        lane0("wrap_b", 32'h508, 1'b0, 32'h0);
        lane1("wrap_b", 32'h50C, 1'b0, 32'h0);
        tick(); out_ready = 1'b0;
        occ("wrap_c", 0, 2'b00, 1'b1);

        // Flush with competing enqueue and dequeue
        push(32'h800, 1'b0, 2'd0, 32'h0);
        push(32'h808, 1'b0, 2'd0, 32'h0);
        occ("pre_flush", 6, 2'b11, 1'b1);
        set_group(32'h900, 1'b1, 2'd3, 32'hABC);
        out_ready = 1'b1; flush = 1'b1;
        #1;
        lane0("flush_cycle", 32'h800, 1'b0, 32'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        occ("post_flush", 0, 2'b00, 1'b1);
        push(32'hA00, 1'b0, 2'd0, 32'h0);
        occ("after_flush", 4, 2'b11, 1'b1);
        lane0("after_flush", 32'hA00, 1'b0, 32'h0);

        // Simultaneous enqueue and dequeue
        out_ready = 1'b1;
        push(32'hB08, 1'b1, 2'd3, 32'hC00);
        occ("simul", 4, 2'b11, 1'b1);
        lane0("simul", 32'hA08, 1'b0, 32'h0);
        tick();
        lane0("simul_b", 32'hB08, 1'b0, 32'h0);
        lane1("simul_b", 32'hB0C, 1'b1, 32'hC00);
        out_ready = 1'b0;

        // Reset mid-stream
        push(32'hD00, 1'b0, 2'd0, 32'h0);
        reset = 1'b1; tick(); reset = 1'b0;
        #1;
        occ("rst_mid", 0, 2'b00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
